// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen: parametrised VGA sync/position generator with pixel-clock |
// | enable divider. Optional frame counter: define VGA_FRAMECOUNT_EN.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          bright,
  output logic [CW-1:0] pxcounter,
  output logic [CW-1:0] linecounter,
  output logic          px_tick,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAMECOUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_FP_START   = H_ACTIVE;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_BP_START   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_FP_START   = V_ACTIVE;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_BP_START   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } region_t;

  function automatic region_t region_of(input int pos, input int fp_s,
                                        input int sync_s, input int bp_s);
    region_t r;
    if (pos < fp_s)        r = ST_ACTIVE;
    else if (pos < sync_s) r = ST_FP;
    else if (pos < bp_s)   r = ST_SYNC;
    else                   r = ST_BP;
    return r;
  endfunction

  // Later boundaries win so zero-width regions are skipped cleanly.
  function automatic region_t region_step(input region_t cur, input int pos,
                                          input int fp_s, input int sync_s,
                                          input int bp_s);
    region_t r;
    r = cur;
    if (pos == 0)      r = ST_ACTIVE;
    if (pos == fp_s)   r = ST_FP;
    if (pos == sync_s) r = ST_SYNC;
    if (pos == bp_s)   r = ST_BP;
    return r;
  endfunction

  localparam region_t H_RST = region_of(H_TOTAL - 1, H_FP_START, H_SYNC_START, H_BP_START);
  localparam region_t V_RST = region_of(V_TOTAL - 1, V_FP_START, V_SYNC_START, V_BP_START);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] ln_q, ln_d;
  region_t       hst_q, hst_d;
  region_t       vst_q, vst_d;
  logic          hsync_q, vsync_q, bright_q;
  logic          px_tick_q, line_start_q, frame_start_q;
  logic          tick, px_wrap, at_origin;

  always_comb begin
    tick      = enable && (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DW'(1);
    px_wrap   = (px_q == H_LAST);
    px_d      = px_wrap ? '0 : px_q + CW'(1);
    ln_d      = ln_q;
    if (px_wrap) begin
      ln_d = (ln_q == V_LAST) ? '0 : ln_q + CW'(1);
    end
    hst_d     = region_step(hst_q, int'(px_d), H_FP_START, H_SYNC_START, H_BP_START);
    vst_d     = vst_q;
    if (px_wrap) begin
      vst_d = region_step(vst_q, int'(ln_d), V_FP_START, V_SYNC_START, V_BP_START);
    end
    at_origin = (px_d == '0) && (ln_d == '0);
  end

  // Levels are computed from the next-state regions so they land on the same
  // edge as the counters they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      px_q          <= H_LAST;
      ln_q          <= V_LAST;
      hst_q         <= H_RST;
      vst_q         <= V_RST;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      bright_q      <= 1'b0;
      px_tick_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      px_tick_q     <= tick;
      line_start_q  <= tick && (px_d == '0);
      frame_start_q <= tick && at_origin;
      if (enable) begin
        div_q <= div_d;
      end
      if (tick) begin
        px_q     <= px_d;
        ln_q     <= ln_d;
        hst_q    <= hst_d;
        vst_q    <= vst_d;
        hsync_q  <= (hst_d == ST_SYNC) ? HS_POL : ~HS_POL;
        vsync_q  <= (vst_d == ST_SYNC) ? VS_POL : ~VS_POL;
        bright_q <= (hst_d == ST_ACTIVE) && (vst_d == ST_ACTIVE);
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign bright      = bright_q;
  assign pxcounter   = px_q;
  assign linecounter = ln_q;
  assign px_tick     = px_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAMECOUNT_EN
  logic [15:0] fc_q;
  logic        armed_q;

  // The (0,0) presented by the first tick after reset is not a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q    <= '0;
      armed_q <= 1'b0;
    end else if (tick && at_origin) begin
      if (armed_q) begin
        fc_q <= fc_q + 16'd1;
      end
      armed_q <= 1'b1;
    end
  end

  assign frame_count = fc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised-enable bench: three vga_timing_gen configurations checked every
// cycle against an arithmetic position model (ticks -> linear frame index).

module tb_vga_timing_gen;

  // Per-instance configuration: a = defaults, b = small odd divider, c = 8x6 CLK_DIV=1
  localparam int   HA[3] = '{640, 10, 4};
  localparam int   HF[3] = '{16,  2,  1};
  localparam int   HS[3] = '{96,  3,  2};
  localparam int   HB[3] = '{48,  4,  1};
  localparam int   VA[3] = '{480, 6,  3};
  localparam int   VF[3] = '{10,  1,  1};
  localparam int   VS[3] = '{2,   2,  1};
  localparam int   VB[3] = '{33,  3,  1};
  localparam int   CD[3] = '{2,   3,  1};
  localparam logic HP[3] = '{1'b0, 1'b0, 1'b1};
  localparam logic VP[3] = '{1'b0, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] en = 3'b111;

  always #5 clk = ~clk;

  logic        a_hs, a_vs, a_br, a_pt, a_ls, a_fs;
  logic [10:0] a_px, a_ln;
  logic        b_hs, b_vs, b_br, b_pt, b_ls, b_fs;
  logic [5:0]  b_px, b_ln;
  logic        c_hs, c_vs, c_br, c_pt, c_ls, c_fs;
  logic [3:0]  c_px, c_ln;
`ifdef VGA_FRAMECOUNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .enable(en[0]),
    .hsync(a_hs), .vsync(a_vs), .bright(a_br),
    .pxcounter(a_px), .linecounter(a_ln),
    .px_tick(a_pt), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAMECOUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .CW(6)
  ) u_b (
    .clk(clk), .reset(reset), .enable(en[1]),
    .hsync(b_hs), .vsync(b_vs), .bright(b_br),
    .pxcounter(b_px), .linecounter(b_ln),
    .px_tick(b_pt), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAMECOUNT_EN
    , .frame_count(b_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) u_c (
    .clk(clk), .reset(reset), .enable(en[2]),
    .hsync(c_hs), .vsync(c_vs), .bright(c_br),
    .pxcounter(c_px), .linecounter(c_ln),
    .px_tick(c_pt), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAMECOUNT_EN
    , .frame_count(c_fc)
`endif
  );

  // Model state: enabled cycles since reset and whether the last edge ticked.
  int n_en[3]  = '{0, 0, 0};
  bit pulse[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        n_en[i]  <= 0;
        pulse[i] <= 1'b0;
      end else if (en[i]) begin
        n_en[i]  <= n_en[i] + 1;
        pulse[i] <= ((n_en[i] + 1) % CD[i]) == 0;
      end else begin
        pulse[i] <= 1'b0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_dut(input int id, input string nm,
                           input logic hs, input logic vs, input logic br,
                           input logic pt, input logic ls, input logic fs,
                           input int px, input int ln);
    int ht, vt, k, p, epx, eln;
    logic ehs, evs, ebr;
    ht = HA[id] + HF[id] + HS[id] + HB[id];
    vt = VA[id] + VF[id] + VS[id] + VB[id];
    k  = n_en[id] / CD[id];
    if (k == 0) begin
      epx = ht - 1;
      eln = vt - 1;
    end else begin
      p   = (k - 1) % (ht * vt);
      epx = p % ht;
      eln = p / ht;
    end
    ebr = (k > 0) && (epx < HA[id]) && (eln < VA[id]);
    ehs = ((k > 0) && (epx >= HA[id] + HF[id]) && (epx < HA[id] + HF[id] + HS[id]))
          ? HP[id] : ~HP[id];
    evs = ((k > 0) && (eln >= VA[id] + VF[id]) && (eln < VA[id] + VF[id] + VS[id]))
          ? VP[id] : ~VP[id];
    check({nm, ".px"},     px, epx);
    check({nm, ".ln"},     ln, eln);
    check({nm, ".bright"}, {31'd0, br}, {31'd0, ebr});
    check({nm, ".hsync"},  {31'd0, hs}, {31'd0, ehs});
    check({nm, ".vsync"},  {31'd0, vs}, {31'd0, evs});
    check({nm, ".px_tick"},     {31'd0, pt}, {31'd0, pulse[id]});
    check({nm, ".line_start"},  {31'd0, ls}, {31'd0, pulse[id] && epx == 0});
    check({nm, ".frame_start"}, {31'd0, fs}, {31'd0, pulse[id] && epx == 0 && eln == 0});
  endtask

`ifdef VGA_FRAMECOUNT_EN
  function automatic int exp_fc(input int id);
    int ft, k;
    ft = (HA[id] + HF[id] + HS[id] + HB[id]) * (VA[id] + VF[id] + VS[id] + VB[id]);
    k  = n_en[id] / CD[id];
    return (k == 0) ? 0 : ((k - 1) / ft) % 65536;
  endfunction
`endif

  task automatic step();
    @(negedge clk);
    check_dut(0, "a", a_hs, a_vs, a_br, a_pt, a_ls, a_fs, int'(a_px), int'(a_ln));
    check_dut(1, "b", b_hs, b_vs, b_br, b_pt, b_ls, b_fs, int'(b_px), int'(b_ln));
    check_dut(2, "c", c_hs, c_vs, c_br, c_pt, c_ls, c_fs, int'(c_px), int'(c_ln));
`ifdef VGA_FRAMECOUNT_EN
    check("a.frame_count", {16'd0, a_fc}, exp_fc(0));
    check("b.frame_count", {16'd0, b_fc}, exp_fc(1));
    check("c.frame_count", {16'd0, c_fc}, exp_fc(2));
`endif
  endtask

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      for (int i = 0; i < 3; i++) en[i] = ($urandom_range(7) != 0);
    end
  endtask

  initial begin
    int lat_a, lat_b, lat_c, found;
    reset = 1'b1;
    en    = 3'b111;
    repeat (3) step();
    reset = 1'b0;

    lat_a = -1; lat_b = -1; lat_c = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (a_fs && lat_a < 0) lat_a = i;
      if (b_fs && lat_b < 0) lat_b = i;
      if (c_fs && lat_c < 0) lat_c = i;
    end
    check("a.first_tick_edge", lat_a, 2);
    check("b.first_tick_edge", lat_b, 3);
    check("c.first_tick_edge", lat_c, 1);

    random_run(6000);

    en = 3'b111;
    found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      step();
      if (a_px == 11'd100 && a_pt) found = 1;
    end
    check("a.reach_px100", found, 1);
    en[0] = 1'b0;
    repeat (37) begin
      step();
      check("a.frozen_px", {21'd0, a_px}, 100);
      check("a.frozen_tick", {31'd0, a_pt}, 0);
    end
    en[0] = 1'b1;
    step();
    step();
    check("a.resume_px", {21'd0, a_px}, 101);
    check("a.resume_tick", {31'd0, a_pt}, 1);

    random_run(500);
    reset = 1'b1;
    step();
    check("a.reset_px", {21'd0, a_px}, 799);
    check("a.reset_ln", {21'd0, a_ln}, 524);
    check("a.reset_bright", {31'd0, a_br}, 0);
    check("a.reset_hsync", {31'd0, a_hs}, 1);
    check("a.reset_vsync", {31'd0, a_vs}, 1);
    reset = 1'b0;
    random_run(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
